// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bundle between decode and reg_scoreboard, plus the scoreboard status outputs.
interface reg_scoreboard_if #(
   parameter int NREGS        = 32,
   parameter int MAX_INFLIGHT = 8
);
   localparam int AW = $clog2(NREGS);
   localparam int CW = $clog2(MAX_INFLIGHT + 1);

   logic              issue_valid;
   logic [AW-1:0]     rs_a;
   logic [AW-1:0]     rt_a;
   logic [AW-1:0]     fs_a;
   logic [AW-1:0]     ft_a;
   logic [3:0]        src_use;
   logic              dst_en;
   logic              dst_fp;
   logic [AW-1:0]     dst_a;
   logic              int_wb_valid;
   logic [AW-1:0]     int_wb_dst;
   logic              fp_wb_valid;
   logic [AW-1:0]     fp_wb_dst;
   logic              flush;
   logic              stall;
   logic              issue_ok;
   logic [NREGS-1:0]  int_pending;
   logic [NREGS-1:0]  fp_pending;
   logic [CW-1:0]     inflight;
   logic              wb_err;

   modport master (
      output issue_valid, rs_a, rt_a, fs_a, ft_a, src_use, dst_en, dst_fp, dst_a,
             int_wb_valid, int_wb_dst, fp_wb_valid, fp_wb_dst, flush,
      input  stall, issue_ok, int_pending, fp_pending, inflight, wb_err
   );

   modport slave (
      input  issue_valid, rs_a, rt_a, fs_a, ft_a, src_use, dst_en, dst_fp, dst_a,
             int_wb_valid, int_wb_dst, fp_wb_valid, fp_wb_dst, flush,
      output stall, issue_ok, int_pending, fp_pending, inflight, wb_err
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Integer/FP register scoreboard: pending-write bits, RAW/WAW/in-flight-limit stall, sticky wb_err.
// Optional macro SCOREBOARD_BYPASS_EN: hazard checks see same-cycle writeback clears.
module reg_scoreboard #(
   parameter int NREGS        = 32,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic             clk,
   input  logic             reset,
   reg_scoreboard_if.slave  sb
);
   localparam int AW = $clog2(NREGS);
   localparam int CW = $clog2(MAX_INFLIGHT + 1);

   logic [NREGS-1:0] int_pend_q;
   logic [NREGS-1:0] fp_pend_q;
   logic [CW-1:0]    inflight_q;
   logic             wb_err_q;

   logic [NREGS-1:0] eff_int;
   logic [NREGS-1:0] eff_fp;
   logic [NREGS-1:0] int_clr_mask;
   logic [NREGS-1:0] fp_clr_mask;
   logic [NREGS-1:0] int_set_mask;
   logic [NREGS-1:0] fp_set_mask;
   logic             raw_haz;
   logic             waw_haz;
   logic             limit_haz;
   logic             dst_allocs;
   logic             alloc;
   logic             int_ret;
   logic             fp_ret;
   logic             int_err;
   logic             fp_err;
   logic             stall_c;
   logic             issue_ok_c;

   function automatic logic [NREGS-1:0] onehot(input logic en, input logic [AW-1:0] a);
      logic [NREGS-1:0] m;
      m    = '0;
      m[a] = en;
      return m;
   endfunction

   always_comb begin
      int_ret = sb.int_wb_valid & int_pend_q[sb.int_wb_dst];
      fp_ret  = sb.fp_wb_valid & fp_pend_q[sb.fp_wb_dst];
      int_err = sb.int_wb_valid & ~int_pend_q[sb.int_wb_dst];
      fp_err  = sb.fp_wb_valid & ~fp_pend_q[sb.fp_wb_dst];
      int_clr_mask = onehot(int_ret, sb.int_wb_dst);
      fp_clr_mask  = onehot(fp_ret, sb.fp_wb_dst);

`ifdef SCOREBOARD_BYPASS_EN
      eff_int = int_pend_q & ~int_clr_mask;
      eff_fp  = fp_pend_q & ~fp_clr_mask;
`else
      eff_int = int_pend_q;
      eff_fp  = fp_pend_q;
`endif

      // Integer r0 is hardwired: it never hazards as a source and never allocates.
      raw_haz = (sb.src_use[0] & (sb.rs_a != '0) & eff_int[sb.rs_a]) |
                (sb.src_use[1] & (sb.rt_a != '0) & eff_int[sb.rt_a]) |
                (sb.src_use[2] & eff_fp[sb.fs_a]) |
                (sb.src_use[3] & eff_fp[sb.ft_a]);
      dst_allocs = sb.dst_en & (sb.dst_fp | (sb.dst_a != '0));
      waw_haz    = sb.dst_en & (sb.dst_fp ? eff_fp[sb.dst_a] : eff_int[sb.dst_a]);
      // Registered count only; a retiring write this cycle does not free a slot early.
      limit_haz  = dst_allocs & (inflight_q == CW'(MAX_INFLIGHT));

      stall_c    = sb.issue_valid & (raw_haz | waw_haz | limit_haz);
      issue_ok_c = sb.issue_valid & ~stall_c & ~sb.flush;
      alloc      = issue_ok_c & dst_allocs;
      int_set_mask = onehot(alloc & ~sb.dst_fp, sb.dst_a);
      fp_set_mask  = onehot(alloc & sb.dst_fp, sb.dst_a);
   end

   // State update: set after clear so a same-register issue wins over its writeback.
   always_ff @(posedge clk) begin
      if (reset) begin
         int_pend_q <= '0;
         fp_pend_q  <= '0;
         inflight_q <= '0;
         wb_err_q   <= 1'b0;
      end else begin
         int_pend_q <= (int_pend_q & ~int_clr_mask) | int_set_mask;
         fp_pend_q  <= (fp_pend_q & ~fp_clr_mask) | fp_set_mask;
         inflight_q <= inflight_q + CW'(alloc) - CW'(int_ret) - CW'(fp_ret);
         wb_err_q   <= wb_err_q | int_err | fp_err;
      end
   end

   assign sb.stall       = stall_c;
   assign sb.issue_ok    = issue_ok_c;
   assign sb.int_pending = int_pend_q;
   assign sb.fp_pending  = fp_pend_q;
   assign sb.inflight    = inflight_q;
   assign sb.wb_err      = wb_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed-vector bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;
   logic clk;
   logic reset;
   int   n_chk;
   int   n_err;

   reg_scoreboard_if #(.NREGS(32), .MAX_INFLIGHT(8)) sb ();

   reg_scoreboard #(.NREGS(32), .MAX_INFLIGHT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      sb.issue_valid  = 1'b0;
      sb.rs_a         = '0;
      sb.rt_a         = '0;
      sb.fs_a         = '0;
      sb.ft_a         = '0;
      sb.src_use      = '0;
      sb.dst_en       = 1'b0;
      sb.dst_fp       = 1'b0;
      sb.dst_a        = '0;
      sb.int_wb_valid = 1'b0;
      sb.int_wb_dst   = '0;
      sb.fp_wb_valid  = 1'b0;
      sb.fp_wb_dst    = '0;
      sb.flush        = 1'b0;
   endtask

   task automatic issue(input logic fp, input logic [4:0] d, input logic [3:0] use_m,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] fs, input logic [4:0] ft);
      sb.issue_valid = 1'b1;
      sb.dst_en      = 1'b1;
      sb.dst_fp      = fp;
      sb.dst_a       = d;
      sb.src_use     = use_m;
      sb.rs_a        = rs;
      sb.rt_a        = rt;
      sb.fs_a        = fs;
      sb.ft_a        = ft;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      idle();
      reset = 1'b1;
      step();
      step();
      check("rst_int_pending", sb.int_pending, 32'h0);
      check("rst_fp_pending", sb.fp_pending, 32'h0);
      check("rst_inflight", 32'(sb.inflight), 32'h0);
      check("rst_wb_err", 32'(sb.wb_err), 32'h0);
      reset = 1'b0;

      // ADDI to int 5
      issue(1'b0, 5'd5, 4'b0001, 5'd1, 5'd0, 5'd0, 5'd0);
      #1;
      check("addi_issue_ok", 32'(sb.issue_ok), 32'h1);
      check("addi_stall", 32'(sb.stall), 32'h0);
      step();
      idle();
      check("addi_int_pending", sb.int_pending, 32'h20);
      check("addi_inflight", 32'(sb.inflight), 32'h1);

      // RAW on rs=5, then the same with a same-cycle writeback of int 5
      issue(1'b0, 5'd7, 4'b0001, 5'd5, 5'd0, 5'd0, 5'd0);
      #1;
      check("raw_stall", 32'(sb.stall), 32'h1);
      check("raw_issue_ok", 32'(sb.issue_ok), 32'h0);
      sb.int_wb_valid = 1'b1;
      sb.int_wb_dst   = 5'd5;
      #1;
`ifdef SCOREBOARD_BYPASS_EN
      check("raw_wb_stall", 32'(sb.stall), 32'h0);
`else
      check("raw_wb_stall", 32'(sb.stall), 32'h1);
`endif
      sb.issue_valid = 1'b0;
      step();
      idle();
      check("wb5_int_pending", sb.int_pending, 32'h0);
      check("wb5_inflight", 32'(sb.inflight), 32'h0);

      // LWC1 to fp 3, then ADDS hazards
      issue(1'b1, 5'd3, 4'b0001, 5'd2, 5'd0, 5'd0, 5'd0);
      step();
      idle();
      check("lwc1_fp_pending", sb.fp_pending, 32'h08);
      issue(1'b1, 5'd6, 4'b1100, 5'd0, 5'd0, 5'd3, 5'd4);
      #1;
      check("adds_fs3_stall", 32'(sb.stall), 32'h1);
      sb.fs_a = 5'd4;
      sb.ft_a = 5'd5;
      #1;
      check("adds_fs4_stall", 32'(sb.stall), 32'h0);
      check("adds_fs4_issue_ok", 32'(sb.issue_ok), 32'h1);
      step();
      idle();
      check("adds_fp_pending", sb.fp_pending, 32'h48);
      check("adds_inflight", 32'(sb.inflight), 32'h2);
      sb.fp_wb_valid = 1'b1;
      sb.fp_wb_dst   = 5'd3;
      step();
      sb.fp_wb_dst   = 5'd6;
      step();
      idle();
      check("fp_drain_pending", sb.fp_pending, 32'h0);
      check("fp_drain_inflight", 32'(sb.inflight), 32'h0);

      // Fill to the in-flight limit: int 1..4, fp 10..13
      for (int i = 0; i < 8; i++) begin
         if (i < 4) issue(1'b0, 5'(i + 1), 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
         else       issue(1'b1, 5'(i + 6), 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
         #1;
         check($sformatf("fill_issue_ok_%0d", i), 32'(sb.issue_ok), 32'h1);
         step();
         idle();
      end
      check("full_int_pending", sb.int_pending, 32'h1E);
      check("full_fp_pending", sb.fp_pending, 32'h3C00);
      check("full_inflight", 32'(sb.inflight), 32'h8);

      // 9th allocating issue stalls despite a same-cycle writeback
      issue(1'b0, 5'd20, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
      sb.int_wb_valid = 1'b1;
      sb.int_wb_dst   = 5'd1;
      #1;
      check("limit_stall", 32'(sb.stall), 32'h1);
      step();
      sb.int_wb_valid = 1'b0;
      #1;
      check("limit_retry_stall", 32'(sb.stall), 32'h0);
      check("limit_retry_issue_ok", 32'(sb.issue_ok), 32'h1);
      step();
      idle();
      check("limit_int_pending", sb.int_pending, 32'h0010_001C);
      check("limit_inflight", 32'(sb.inflight), 32'h8);

      // dst int 0 at full count: no allocation, no LIMIT; rs=0 never stalls
      issue(1'b0, 5'd0, 4'b0001, 5'd0, 5'd0, 5'd0, 5'd0);
      #1;
      check("r0_stall", 32'(sb.stall), 32'h0);
      check("r0_issue_ok", 32'(sb.issue_ok), 32'h1);
      step();
      idle();
      check("r0_int_pending", sb.int_pending, 32'h0010_001C);
      check("r0_inflight", 32'(sb.inflight), 32'h8);

      // Retire from both files in one cycle
      sb.int_wb_valid = 1'b1;
      sb.int_wb_dst   = 5'd2;
      sb.fp_wb_valid  = 1'b1;
      sb.fp_wb_dst    = 5'd10;
      step();
      idle();
      check("dual_int_pending", sb.int_pending, 32'h0010_0018);
      check("dual_fp_pending", sb.fp_pending, 32'h3800);
      check("dual_inflight", 32'(sb.inflight), 32'h6);

      // Flushed issue does not allocate; its writeback still retires
      issue(1'b0, 5'd9, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
      sb.flush        = 1'b1;
      sb.int_wb_valid = 1'b1;
      sb.int_wb_dst   = 5'd4;
      #1;
      check("flush_issue_ok", 32'(sb.issue_ok), 32'h0);
      check("flush_stall", 32'(sb.stall), 32'h0);
      step();
      idle();
      check("flush_int_pending", sb.int_pending, 32'h0010_0008);
      check("flush_inflight", 32'(sb.inflight), 32'h5);

      // Writeback to a non-pending register is sticky
      sb.fp_wb_valid = 1'b1;
      sb.fp_wb_dst   = 5'd9;
      step();
      idle();
      check("wberr_set", 32'(sb.wb_err), 32'h1);
      check("wberr_fp_pending", sb.fp_pending, 32'h3800);
      check("wberr_inflight", 32'(sb.inflight), 32'h5);
      step();
      check("wberr_sticky", 32'(sb.wb_err), 32'h1);

      // Reset wins over a concurrent issue
      issue(1'b0, 5'd11, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle();
      check("rst2_int_pending", sb.int_pending, 32'h0);
      check("rst2_fp_pending", sb.fp_pending, 32'h0);
      check("rst2_inflight", 32'(sb.inflight), 32'h0);
      check("rst2_wb_err", 32'(sb.wb_err), 32'h0);
      check("rst2_stall", 32'(sb.stall), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
